// File: rtl/usb_tx_pkg.sv
// USB TX bit-stuffer shared types and constants.
// Optional build macro: SYNC_GEN_EN (automatic SYNC prefix).
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        STUFF,
        EOP
    } tx_state_e;

    localparam logic [7:0] USB_SYNC_BYTE = 8'h80;
    localparam int unsigned STUFF_RUN_DEF = 6;
    localparam int unsigned EOP_BITS_DEF = 2;
    localparam int unsigned CLKS_PER_BIT_DEF = 8;

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-period tick generator with synchronous clear.
// tick is high on the terminal count of a free-running 0..N-1 counter.
module usb_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [7:0] TERM = 8'(CLKS_PER_BIT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // wrap at terminal count, restart on clear
    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clr || (cnt_q == TERM)) begin
            cnt_d = '0;
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == TERM);

endmodule

// File: rtl/usb_tx_bitstuff.sv
// USB TX serializer with bit stuffing, feeding nrzi_encode.
// Optional build macro: SYNC_GEN_EN prefixes each packet with SYNC.
module usb_tx_bitstuff
    import usb_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned EOP_BITS     = EOP_BITS_DEF,
    parameter int unsigned STUFF_RUN    = STUFF_RUN_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_orig,
    output logic       bit_strobe,
    output logic       eop,
    output logic       busy,
    output logic       underrun
);

    localparam logic [3:0] RUN      = 4'(STUFF_RUN);
    localparam logic [2:0] EOP_LAST = 3'(EOP_BITS - 1);

    tx_state_e  state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] ones_q, ones_d;
    logic       last_q, last_d;
    logic       sync_q, sync_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_last_q, hold_last_d;
    logic       hold_full_q, hold_full_d;
    logic       d_orig_q, d_orig_d;
    logic       strobe_q, strobe_d;
    logic       eop_q, eop_d;
    logic [2:0] eop_cnt_q, eop_cnt_d;
    logic       underrun_q, underrun_d;

    logic       timer_clr;
    logic       tick;
    logic       advance;
    logic       load_byte;
    logic [3:0] ones_base;

    usb_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (timer_clr),
        .tick(tick)
    );

    // next-state, bit selection, stuffing and holding-register control
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        idx_d       = idx_q;
        ones_d      = ones_q;
        last_d      = last_q;
        sync_d      = sync_q;
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        hold_full_d = hold_full_q;
        d_orig_d    = d_orig_q;
        strobe_d    = 1'b0;
        eop_d       = eop_q;
        eop_cnt_d   = eop_cnt_q;
        underrun_d  = 1'b0;
        timer_clr   = 1'b0;
        advance     = 1'b0;
        load_byte   = 1'b0;
        ones_base   = '0;

        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_last_d = tx_last;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                timer_clr = 1'b1;
                d_orig_d  = 1'b1;
                eop_d     = 1'b0;
                if (hold_full_q) begin
`ifdef SYNC_GEN_EN
                    sr_d     = USB_SYNC_BYTE;
                    idx_d    = '0;
                    ones_d   = '0;
                    last_d   = 1'b0;
                    sync_d   = 1'b1;
                    d_orig_d = USB_SYNC_BYTE[0];
                    strobe_d = 1'b1;
                    state_d  = SHIFT;
`else
                    load_byte = 1'b1;
`endif
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!sync_q && (ones_q == RUN)) begin
                        state_d  = STUFF;
                        d_orig_d = 1'b0;
                        strobe_d = 1'b1;
                        ones_d   = '0;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            STUFF: begin
                if (tick) begin
                    advance = 1'b1;
                end
            end
            EOP: begin
                if (tick) begin
                    if (eop_cnt_q == EOP_LAST) begin
                        state_d = IDLE;
                        eop_d   = 1'b0;
                    end else begin
                        eop_cnt_d = eop_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // next data bit, or the byte-boundary decision
        if (advance) begin
            if (idx_q != 3'd7) begin
                idx_d    = idx_q + 3'd1;
                sr_d     = sr_q >> 1;
                d_orig_d = sr_q[1];
                strobe_d = 1'b1;
                state_d  = SHIFT;
                if (!sync_q) begin
                    ones_d = sr_q[1] ? (ones_q + 4'd1) : 4'd0;
                end
            end else if (sync_q) begin
                load_byte = 1'b1;
                ones_base = 4'd1;
            end else if (last_q) begin
                state_d   = EOP;
                eop_d     = 1'b1;
                d_orig_d  = 1'b1;
                eop_cnt_d = '0;
            end else if (hold_full_q) begin
                load_byte = 1'b1;
                ones_base = ones_q;
            end else begin
                state_d    = EOP;
                eop_d      = 1'b1;
                d_orig_d   = 1'b1;
                eop_cnt_d  = '0;
                underrun_d = 1'b1;
            end
        end

        // move the holding register into the shifter and emit its bit0
        if (load_byte) begin
            sr_d        = hold_q;
            idx_d       = '0;
            last_d      = hold_last_q;
            sync_d      = 1'b0;
            hold_full_d = 1'b0;
            d_orig_d    = hold_q[0];
            strobe_d    = 1'b1;
            ones_d      = hold_q[0] ? (ones_base + 4'd1) : 4'd0;
            state_d     = SHIFT;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            idx_q       <= '0;
            ones_q      <= '0;
            last_q      <= 1'b0;
            sync_q      <= 1'b0;
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            d_orig_q    <= 1'b1;
            strobe_q    <= 1'b0;
            eop_q       <= 1'b0;
            eop_cnt_q   <= '0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            idx_q       <= idx_d;
            ones_q      <= ones_d;
            last_q      <= last_d;
            sync_q      <= sync_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
            d_orig_q    <= d_orig_d;
            strobe_q    <= strobe_d;
            eop_q       <= eop_d;
            eop_cnt_q   <= eop_cnt_d;
            underrun_q  <= underrun_d;
        end
    end

    assign tx_ready   = !hold_full_q;
    assign d_orig     = d_orig_q;
    assign bit_strobe = strobe_q;
    assign eop        = eop_q;
    assign busy       = (state_q != IDLE);
    assign underrun   = underrun_q;

endmodule
